// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA priority arbiter: HRQ/HLDA handshake, fixed or rotating priority,
// registered one-hot DACK. A small checker module for the acknowledge outputs follows the arbiter.
module dma_priority_arbiter (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] DREQ,
   input  logic [3:0] maskReg,
   input  logic       rotatingPriority,
   input  logic       HLDA,
   input  logic       serviceDone,
   output logic       HRQ,
   output logic [3:0] DACK,
   output logic       grantValid,
   output logic [1:0] grantChannel
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      GRANT   = 2'd2
   } state_t;

   state_t     state_r;
   state_t     state_s;
   logic [1:0] top_ptr_r;
   logic [1:0] top_ptr_s;
   logic [1:0] chan_r;
   logic [1:0] chan_s;
   logic [1:0] winner_s;
   logic [1:0] base_s;
   logic [1:0] idx_s;
   logic [3:0] pending_s;
   logic       found_s;

   function automatic logic [3:0] one_hot(input logic [1:0] ch);
      logic [3:0] oh;
      case (ch)
         2'd0:    oh = 4'b0001;
         2'd1:    oh = 4'b0010;
         2'd2:    oh = 4'b0100;
         2'd3:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

   assign pending_s = DREQ & ~maskReg;

   // Priority search: scan from the lowest-priority slot upward so the top slot wins last.
   always_comb begin
      winner_s = 2'd0;
      found_s  = 1'b0;
      idx_s    = 2'd0;
      if (rotatingPriority) begin
         base_s = top_ptr_r;
      end else begin
         base_s = 2'd0;
      end
      for (int i = 3; i >= 0; i--) begin
         idx_s = base_s + 2'(i);
         if (pending_s[idx_s]) begin
            winner_s = idx_s;
            found_s  = 1'b1;
         end else begin
            found_s  = found_s;
         end
      end
   end

   // Next-state, latched channel and priority pointer update.
   always_comb begin
      state_s   = state_r;
      chan_s    = chan_r;
      top_ptr_s = top_ptr_r;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               state_s = REQUEST;
            end else begin
               state_s = IDLE;
            end
         end
         REQUEST: begin
            if (!found_s) begin
               state_s = IDLE;
            end else if (HLDA) begin
               state_s = GRANT;
               chan_s  = winner_s;
            end else begin
               state_s = REQUEST;
            end
         end
         GRANT: begin
            // serviceDone outranks a simultaneous HLDA drop.
            if (serviceDone) begin
               state_s = IDLE;
               if (rotatingPriority) begin
                  top_ptr_s = chan_r + 2'd1;
               end else begin
                  top_ptr_s = top_ptr_r;
               end
            end else if (!HLDA) begin
               state_s = IDLE;
            end else begin
               state_s = GRANT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State registers; outputs are registered from the next-state decode so they track the state.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r      <= IDLE;
         top_ptr_r    <= 2'd0;
         chan_r       <= 2'd0;
         HRQ          <= 1'b0;
         DACK         <= 4'b0000;
         grantValid   <= 1'b0;
         grantChannel <= 2'd0;
      end else begin
         state_r      <= state_s;
         top_ptr_r    <= top_ptr_s;
         chan_r       <= chan_s;
         HRQ          <= (state_s != IDLE);
         grantValid   <= (state_s == GRANT);
         grantChannel <= (state_s == GRANT) ? chan_s : 2'd0;
         DACK         <= (state_s == GRANT) ? one_hot(chan_s) : 4'b0000;
      end
   end

endmodule

// Acknowledge-output checker: DACK one-hot-or-zero and consistent with the grant outputs.
module dma_priority_arbiter_chk (
   input logic       CLK,
   input logic       RESET,
   input logic       HRQ,
   input logic [3:0] DACK,
   input logic       grantValid,
   input logic [1:0] grantChannel
);

   a_dack_onehot0: assert property (@(posedge CLK) $onehot0(DACK))
      else $error("dack not one-hot-or-zero: %b", DACK);

   a_dack_needs_grant: assert property (@(posedge CLK) disable iff (RESET)
      (DACK != 4'b0000) |-> (grantValid && HRQ && (DACK == (4'b0001 << grantChannel))))
      else $error("dack inconsistent with grant: %b ch %0d", DACK, grantChannel);

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter; all expected values are hand-derived.
module tb_dma_priority_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] dreq;
   logic [3:0] mask;
   logic       rot;
   logic       hlda;
   logic       sdone;
   logic       hrq;
   logic [3:0] dack;
   logic       gv;
   logic [1:0] gch;

   int tests_run    = 0;
   int tests_failed = 0;

   dma_priority_arbiter dut (
      .CLK              (clk),
      .RESET            (rst),
      .DREQ             (dreq),
      .maskReg          (mask),
      .rotatingPriority (rot),
      .HLDA             (hlda),
      .serviceDone      (sdone),
      .HRQ              (hrq),
      .DACK             (dack),
      .grantValid       (gv),
      .grantChannel     (gch)
   );

   dma_priority_arbiter_chk chk (
      .CLK          (clk),
      .RESET        (rst),
      .HRQ          (hrq),
      .DACK         (dack),
      .grantValid   (gv),
      .grantChannel (gch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; dreq = 4'b1111; mask = 4'b0000; rot = 1'b0; hlda = 1'b1; sdone = 1'b0;
      #3;
      tests_run++;
      if ({hrq, dack, gv, gch} !== 8'b0) begin
         tests_failed++; $display("FAIL reset_async: got %b expected %b", {hrq, dack, gv, gch}, 8'b0);
      end
      tick(); tick();
      tests_run++;
      if ({hrq, dack, gv, gch} !== 8'b0) begin
         tests_failed++; $display("FAIL reset_held: got %b expected %b", {hrq, dack, gv, gch}, 8'b0);
      end
      rst = 1'b0; dreq = 4'b0000; hlda = 1'b0;
      tick();
   endtask

   task automatic test_fixed_basic();
      rot = 1'b0; mask = 4'b0000; dreq = 4'b0110; hlda = 1'b0;
      tick();
      tests_run++;
      if (hrq !== 1'b1 || dack !== 4'b0000 || gv !== 1'b0) begin
         tests_failed++; $display("FAIL fixed_request: hrq %b dack %b gv %b expected 1 0000 0", hrq, dack, gv);
      end
      hlda = 1'b1;
      tick();
      tests_run++;
      if (dack !== 4'b0010 || gch !== 2'd1 || gv !== 1'b1 || hrq !== 1'b1) begin
         tests_failed++; $display("FAIL fixed_grant: dack %b ch %0d gv %b hrq %b expected 0010 1 1 1", dack, gch, gv, hrq);
      end
      dreq = 4'b0001; mask = 4'b0010;
      tick();
      tests_run++;
      if (dack !== 4'b0010 || gch !== 2'd1) begin
         tests_failed++; $display("FAIL grant_stable: dack %b ch %0d expected 0010 1", dack, gch);
      end
      sdone = 1'b1; dreq = 4'b0000; mask = 4'b0000;
      tick();
      sdone = 1'b0;
      tests_run++;
      if (dack !== 4'b0000 || hrq !== 1'b0 || gv !== 1'b0 || gch !== 2'd0) begin
         tests_failed++; $display("FAIL fixed_done: dack %b hrq %b gv %b ch %0d expected 0000 0 0 0", dack, hrq, gv, gch);
      end
   endtask

   task automatic test_rotating_wrap();
      logic [1:0] exp_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [3:0] exp_dack;
      rot = 1'b1; dreq = 4'b1111; hlda = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick(); tick();
         exp_dack = 4'b0001 << exp_seq[k];
         tests_run++;
         if (gch !== exp_seq[k] || dack !== exp_dack) begin
            tests_failed++; $display("FAIL rotate_order[%0d]: ch %0d dack %b expected %0d %b", k, gch, dack, exp_seq[k], exp_dack);
         end
         sdone = 1'b1;
         tick();
         sdone = 1'b0;
      end
      dreq = 4'b0000;
      tick();
   endtask

   task automatic test_mask();
      rot = 1'b0; mask = 4'b0001; dreq = 4'b0001; hlda = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         tests_run++;
         if (hrq !== 1'b0) begin
            tests_failed++; $display("FAIL mask_hold[%0d]: hrq %b expected 0", k, hrq);
         end
      end
      mask = 4'b0000;
      tick();
      tests_run++;
      if (hrq !== 1'b1) begin
         tests_failed++; $display("FAIL mask_clear: hrq %b expected 1", hrq);
      end
      dreq = 4'b0000;
      tick();
   endtask

   task automatic test_request_drop();
      dreq = 4'b1000; hlda = 1'b0;
      tick();
      tests_run++;
      if (hrq !== 1'b1) begin
         tests_failed++; $display("FAIL drop_request: hrq %b expected 1", hrq);
      end
      dreq = 4'b0000; hlda = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         tests_run++;
         if (hrq !== 1'b0 || dack !== 4'b0000) begin
            tests_failed++; $display("FAIL drop_idle[%0d]: hrq %b dack %b expected 0 0000", k, hrq, dack);
         end
      end
      hlda = 1'b0;
   endtask

   // Pointer is 1 here; channel 2 is granted, then the grant is aborted.
   task automatic test_abort();
      rot = 1'b1; dreq = 4'b0100; hlda = 1'b1;
      tick(); tick();
      tests_run++;
      if (gch !== 2'd2 || dack !== 4'b0100) begin
         tests_failed++; $display("FAIL abort_grant: ch %0d dack %b expected 2 0100", gch, dack);
      end
      hlda = 1'b0; dreq = 4'b0000;
      tick();
      tests_run++;
      if (dack !== 4'b0000 || hrq !== 1'b0) begin
         tests_failed++; $display("FAIL abort_drop: dack %b hrq %b expected 0000 0", dack, hrq);
      end
      dreq = 4'b1111; hlda = 1'b1;
      tick(); tick();
      tests_run++;
      if (gch !== 2'd1) begin
         tests_failed++; $display("FAIL abort_ptr_kept: ch %0d expected 1", gch);
      end
      sdone = 1'b1; dreq = 4'b0000;
      tick();
      sdone = 1'b0;
   endtask

   // Pointer is 2: channel 0 granted, then serviceDone together with HLDA low.
   task automatic test_done_and_drop();
      dreq = 4'b0001; hlda = 1'b1;
      tick(); tick();
      tests_run++;
      if (gch !== 2'd0) begin
         tests_failed++; $display("FAIL simul_grant: ch %0d expected 0", gch);
      end
      sdone = 1'b1; hlda = 1'b0; dreq = 4'b0000;
      tick();
      sdone = 1'b0;
      dreq = 4'b1111; hlda = 1'b1;
      tick(); tick();
      tests_run++;
      if (gch !== 2'd1) begin
         tests_failed++; $display("FAIL simul_ptr_update: ch %0d expected 1", gch);
      end
      sdone = 1'b1; dreq = 4'b0000;
      tick();
      sdone = 1'b0;
   endtask

   // Pointer is 2: serviceDone in IDLE and REQUEST must be ignored.
   task automatic test_done_outside_grant();
      sdone = 1'b1; hlda = 1'b0;
      tick();
      tests_run++;
      if (hrq !== 1'b0 || dack !== 4'b0000) begin
         tests_failed++; $display("FAIL done_idle: hrq %b dack %b expected 0 0000", hrq, dack);
      end
      dreq = 4'b0011;
      tick(); tick();
      tests_run++;
      if (hrq !== 1'b1 || gv !== 1'b0) begin
         tests_failed++; $display("FAIL done_request: hrq %b gv %b expected 1 0", hrq, gv);
      end
      sdone = 1'b0; hlda = 1'b1;
      tick();
      tests_run++;
      if (gch !== 2'd0 || dack !== 4'b0001) begin
         tests_failed++; $display("FAIL done_outside_ptr: ch %0d dack %b expected 0 0001", gch, dack);
      end
      sdone = 1'b1; dreq = 4'b0000;
      tick();
      sdone = 1'b0;
   endtask

   // Pointer is 1: fixed-mode service holds it; switching back to rotating uses it.
   task automatic test_mode_change();
      rot = 1'b0; dreq = 4'b1010; hlda = 1'b1;
      tick(); tick();
      tests_run++;
      if (gch !== 2'd1) begin
         tests_failed++; $display("FAIL mode_fixed: ch %0d expected 1", gch);
      end
      sdone = 1'b1; dreq = 4'b0000;
      tick();
      sdone = 1'b0;
      rot = 1'b1; dreq = 4'b1001;
      tick(); tick();
      tests_run++;
      if (gch !== 2'd3 || dack !== 4'b1000) begin
         tests_failed++; $display("FAIL mode_rotating: ch %0d dack %b expected 3 1000", gch, dack);
      end
      sdone = 1'b1; dreq = 4'b0000;
      tick();
      sdone = 1'b0;
   endtask

   // Pointer is 0: service channel 2 (pointer -> 3), regrant 2, then reset mid-grant.
   task automatic test_async_reset();
      rot = 1'b1; dreq = 4'b0100; hlda = 1'b1;
      tick(); tick();
      sdone = 1'b1;
      tick();
      sdone = 1'b0;
      tick(); tick();
      tests_run++;
      if (dack !== 4'b0100 || hrq !== 1'b1) begin
         tests_failed++; $display("FAIL rst_pre_grant: dack %b hrq %b expected 0100 1", dack, hrq);
      end
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if (dack !== 4'b0000 || hrq !== 1'b0 || gv !== 1'b0) begin
         tests_failed++; $display("FAIL rst_mid_grant: dack %b hrq %b gv %b expected 0000 0 0", dack, hrq, gv);
      end
      dreq = 4'b1111;
      tick();
      rst = 1'b0;
      tick(); tick();
      tests_run++;
      if (gch !== 2'd0 || dack !== 4'b0001) begin
         tests_failed++; $display("FAIL rst_ptr_cleared: ch %0d dack %b expected 0 0001", gch, dack);
      end
      sdone = 1'b1; dreq = 4'b0000;
      tick();
      sdone = 1'b0; hlda = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fixed_basic();
      test_rotating_wrap();
      test_mask();
      test_request_drop();
      test_abort();
      test_done_and_drop();
      test_done_outside_grant();
      test_mode_change();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: CLK and RESET.
REQ-002 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  asynchronous active-high reset.
REQ-004 DREQ  input  4  channel DMA requests, active-high, bit n = channel n.
REQ-005 maskReg  input  4  channel masks; 1 = channel ignored.
REQ-006 rotatingPriority  input  1  0 = fixed priority, 1 = rotating priority.
REQ-007 HLDA  input  1  hold acknowledge from the CPU.
REQ-008 serviceDone  input  1  single-cycle pulse from timing-and-control: the current transfer has finished.
REQ-009 HRQ  output  1  hold request to the CPU.
REQ-010 DACK  output  4  one-hot acknowledge to the serviced channel.
REQ-011 grantValid  output  1  channel grant is valid; timing-and-control SHALL leave its idle state on this signal.
REQ-012 grantChannel  output  2  binary index of the granted channel.

Function
REQ-013 pending = DREQ & ~maskReg, evaluated combinationally each cycle.
REQ-014 The FSM SHALL have three states: IDLE, REQUEST and GRANT.
REQ-015 In IDLE, a nonzero pending value SHALL cause a move to REQUEST on the next edge.
REQ-016 In REQUEST, HRQ SHALL be 1.
REQ-017 In REQUEST with HLDA=1 and pending nonzero, the FSM SHALL move to GRANT and latch the winning channel in the same edge.
REQ-018 In REQUEST with pending=0, the FSM SHALL return to IDLE, with HLDA ignored.
REQ-019 In GRANT:
- HRQ=1, grantValid=1;
- grantChannel = latched channel;
- DACK = one-hot of the latched channel;
- all other outputs 0.
REQ-020 In GRANT, changes to DREQ and maskReg SHALL NOT alter the latched channel or end the grant.
REQ-021 In GRANT, serviceDone=1 SHALL move the FSM to IDLE, and the priority pointer SHALL update on the same edge.
REQ-022 In GRANT, HLDA=0 with serviceDone=0 SHALL abort to IDLE without updating the priority pointer.
REQ-023 If serviceDone and HLDA=0 occur in the same cycle, the event SHALL be treated as serviceDone.
REQ-024 All outputs SHALL be registered; DACK, grantValid and grantChannel SHALL be 0 outside GRANT, and HRQ SHALL be 0 in IDLE.
REQ-025 Fixed mode: priority SHALL be channel 0 highest, then channels 1, 2, 3.
REQ-026 Rotating mode: a 2-bit pointer topPtr names the highest-priority channel; order = topPtr, topPtr+1, topPtr+2, topPtr+3, all mod 4.
REQ-027 Pointer update on serviceDone:
- rotating mode: topPtr = grantedChannel+1 mod 4, so the serviced channel becomes lowest priority and channel 3 wraps to 0;
- fixed mode: topPtr is held.
REQ-028 A rotatingPriority change SHALL take effect at the next arbitration; topPtr SHALL NOT be cleared by the change.
REQ-029 serviceDone outside GRANT SHALL be ignored.
REQ-030 At most one DACK bit SHALL ever be 1.
REQ-031 Minimum latency from a pending request in IDLE to DACK is 2 edges, with HLDA already high.

Reset
REQ-032 While RESET=1, outputs SHALL be HRQ=0, DACK=0000, grantValid=0 and grantChannel=00; the FSM SHALL be in IDLE and topPtr=0, independent of CLK.
REQ-033 RESET asserted during GRANT SHALL drop DACK and HRQ immediately (asynchronously).
REQ-034 After RESET deasserts, the first arbitration SHALL use topPtr=0.

Verification
REQ-035 Fixed mode, mask=0000, DREQ=0110, HLDA raised one cycle after HRQ -> HRQ=1, then DACK=0010, grantChannel=1; serviceDone pulse -> IDLE, DACK=0000.
REQ-036 Rotating mode, DREQ=1111 held, four grant/serviceDone cycles with HLDA=1 -> grant order 0,1,2,3, then 0 again (wrap).
REQ-037 maskReg=0001, DREQ=0001 -> HRQ stays 0 for 10 cycles; clearing maskReg -> HRQ=1 on the next edge.
REQ-038 REQUEST state, DREQ drops to 0000 before HLDA -> back to IDLE, HRQ=0, no DACK ever asserted.
REQ-039 GRANT on channel 2, HLDA drops without serviceDone -> DACK=0000 next edge, and the next rotating arbitration still starts at the old topPtr.
REQ-040 RESET asserted mid-GRANT between clock edges -> DACK=0000 and HRQ=0 immediately; a checker asserts DACK is one-hot-or-zero on every cycle.
